// File: rtl/ctr_pkg.sv
// Shared constants and types for the up/down counter block.
package ctr_pkg;

  typedef enum logic {
    CTR_MODE_WRAP = 1'b0,
    CTR_MODE_SAT  = 1'b1
  } ctr_mode_e;

  localparam int unsigned PRESCALE_DIV_MAX = 256;
  localparam int unsigned CTR_WIDTH_MIN    = 2;
  localparam int unsigned CTR_WIDTH_MAX    = 32;

  // Prescaler counter width: clog2(div), never below one bit.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ctr_prescaler.sv
// Enabled-cycle prescaler: tick_o marks the enabled cycle that completes a period.
module ctr_prescaler
  import ctr_pkg::*;
#(
  parameter int unsigned Div = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = presc_width(Div);
  localparam logic [PW-1:0] LAST = PW'(Div - 1);

  if (Div < 1 || Div > PRESCALE_DIV_MAX) begin : g_bad_div
    $error("ctr_prescaler: Div=%0d outside 1..%0d", Div, PRESCALE_DIV_MAX);
  end

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Tick depends only on the phase; the parent qualifies it with en_i.
  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updn_ctr.sv
// Prescaled up/down counter with clear, clamped load, wrap or saturate bounds
// and a registered terminal-count pulse.
module updn_ctr
  import ctr_pkg::*;
#(
  parameter int unsigned Width       = 4,
  parameter int unsigned MaxVal      = 32'((64'd1 << Width) - 64'd1),
  parameter ctr_mode_e   Mode        = CTR_MODE_WRAP,
  parameter int unsigned PrescaleDiv = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] o,
  output logic             tc_o
);

  if (Width < CTR_WIDTH_MIN || Width > CTR_WIDTH_MAX) begin : g_bad_width
    $error("updn_ctr: Width=%0d outside %0d..%0d", Width, CTR_WIDTH_MIN, CTR_WIDTH_MAX);
  end
  if (MaxVal < 1 || 64'(MaxVal) > ((64'd1 << Width) - 64'd1)) begin : g_bad_max
    $error("updn_ctr: MaxVal=%0d not representable in Width=%0d", MaxVal, Width);
  end
  if (PrescaleDiv < 1 || PrescaleDiv > PRESCALE_DIV_MAX) begin : g_bad_div
    $error("updn_ctr: PrescaleDiv=%0d outside 1..%0d", PrescaleDiv, PRESCALE_DIV_MAX);
  end

  localparam logic [Width-1:0] MAX_V = Width'(MaxVal);
  localparam bit               SAT   = (Mode == CTR_MODE_SAT);

  logic             tick;
  logic             step;
  logic [Width-1:0] o_d;
  logic             tc_d;

  // Load also restarts the prescaler phase.
  ctr_prescaler #(
    .Div(PrescaleDiv)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .clr_i  (clr_i | load_i),
    .tick_o (tick)
  );

  assign step = en_i & tick;

  // Next count: clear > load > step > hold; tc flags a step taken at a bound.
  always_comb begin
    o_d  = o;
    tc_d = 1'b0;
    if (clr_i) begin
      o_d = '0;
    end else if (load_i) begin
      o_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
    end else if (step) begin
      if (up_i) begin
        if (o >= MAX_V) begin
          tc_d = 1'b1;
          o_d  = SAT ? MAX_V : '0;
        end else begin
          o_d = o + Width'(1);
        end
      end else begin
        if (o == '0) begin
          tc_d = 1'b1;
          o_d  = SAT ? '0 : MAX_V;
        end else begin
          o_d = o - Width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o    <= '0;
      tc_o <= 1'b0;
    end else begin
      o    <= o_d;
      tc_o <= tc_d;
    end
  end

endmodule

// File: tb/tb_updn_ctr.sv
// Bench for updn_ctr: four configurations share one stimulus stream and are
// checked against directed tables and a behavioural model.
module tb_updn_ctr;
  import ctr_pkg::*;

  localparam int NCFG = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i, up_i, clr_i, load_i;
  logic [3:0] load_val_i;
  logic [3:0] dut_o  [NCFG];
  logic       dut_tc [NCFG];

  // 0: wrap Max9 Div1, 1: sat Max9 Div1, 2: wrap Max9 Div3, 3: sat Max15 Div2
  const int cfg_max [NCFG] = '{9, 9, 9, 15};
  const bit cfg_sat [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b1};
  const int cfg_div [NCFG] = '{1, 1, 3, 2};

  int m_o   [NCFG];
  int m_pre [NCFG];
  bit m_tc  [NCFG];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updn_ctr #(.Width(4), .MaxVal(9), .Mode(CTR_MODE_WRAP), .PrescaleDiv(1)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val_i(load_val_i), .o(dut_o[0]), .tc_o(dut_tc[0]));
  updn_ctr #(.Width(4), .MaxVal(9), .Mode(CTR_MODE_SAT), .PrescaleDiv(1)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val_i(load_val_i), .o(dut_o[1]), .tc_o(dut_tc[1]));
  updn_ctr #(.Width(4), .MaxVal(9), .Mode(CTR_MODE_WRAP), .PrescaleDiv(3)) u_pre (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val_i(load_val_i), .o(dut_o[2]), .tc_o(dut_tc[2]));
  updn_ctr #(.Width(4), .Mode(CTR_MODE_SAT), .PrescaleDiv(2)) u_full (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val_i(load_val_i), .o(dut_o[3]), .tc_o(dut_tc[3]));

  typedef struct {
    bit       clr;
    bit       load;
    bit       en;
    bit       up;
    bit [3:0] lv;
    int       exp_o;
    bit       exp_tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit clr, bit load, bit en, bit up, bit [3:0] lv, int eo, bit etc);
    vec_t v;
    v.clr = clr; v.load = load; v.en = en; v.up = up; v.lv = lv;
    v.exp_o = eo; v.exp_tc = etc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_o[k] = 0; m_pre[k] = 0; m_tc[k] = 1'b0;
    end
  endtask

  // One clock of the counter rules: priority clear, clamped load, prescaled step.
  task automatic model_clk(input bit clr, input bit load, input bit en, input bit up, input int lv);
    for (int k = 0; k < NCFG; k++) begin
      m_tc[k] = 1'b0;
      if (clr) begin
        m_o[k] = 0; m_pre[k] = 0;
      end else if (load) begin
        m_o[k] = (lv > cfg_max[k]) ? cfg_max[k] : lv;
        m_pre[k] = 0;
      end else if (en) begin
        bit tick = (m_pre[k] == cfg_div[k] - 1);
        m_pre[k] = (m_pre[k] + 1) % cfg_div[k];
        if (tick) begin
          if (up) begin
            if (m_o[k] == cfg_max[k]) begin
              m_tc[k] = 1'b1;
              if (!cfg_sat[k]) m_o[k] = 0;
            end else m_o[k] = m_o[k] + 1;
          end else begin
            if (m_o[k] == 0) begin
              m_tc[k] = 1'b1;
              if (!cfg_sat[k]) m_o[k] = cfg_max[k];
            end else m_o[k] = m_o[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic chk_model();
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("model_o[%0d]", k), int'(dut_o[k]), m_o[k]);
      chk($sformatf("model_tc[%0d]", k), int'(dut_tc[k]), int'(m_tc[k]));
    end
  endtask

  // Drive one cycle, advance the model on the edge, sample 1 ns later.
  task automatic cycle(input bit clr, input bit load, input bit en, input bit up, input bit [3:0] lv);
    clr_i = clr; load_i = load; en_i = en; up_i = up; load_val_i = lv;
    @(posedge clk);
    model_clk(clr, load, en, up, int'(lv));
    #1;
    chk_model();
  endtask

  initial begin
    int exp_sat [5];
    int exp_satc[5];
    int exp_pre [10];

    rst_n = 1'b0; en_i = 1'b0; up_i = 1'b0; clr_i = 1'b0; load_i = 1'b0; load_val_i = '0;
    model_reset();
    #12;
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("reset_o[%0d]", k), int'(dut_o[k]), 0);
      chk($sformatf("reset_tc[%0d]", k), int'(dut_tc[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap run 0..9,0,1 then priority, clamp and direction flip at the top.
    for (int i = 1; i <= 11; i++)
      tbl.push_back(mk(0, 0, 1, 1, 4'd0, i % 10, i == 10));
    tbl.push_back(mk(1, 1, 1, 1, 4'd5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4'd14, 9, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 8, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'd0, 8, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 9, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 8, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'd0, 9, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'd0, 0, 1));
    foreach (tbl[i]) begin
      cycle(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv);
      chk($sformatf("tbl%0d_o", i), int'(dut_o[0]), tbl[i].exp_o);
      chk($sformatf("tbl%0d_tc", i), int'(dut_tc[0]), int'(tbl[i].exp_tc));
    end

    // Saturating descent from 2: tc repeats on every step taken at 0.
    exp_sat  = '{1, 0, 0, 0, 0};
    exp_satc = '{0, 0, 1, 1, 1};
    cycle(0, 1, 0, 0, 4'd2);
    chk("sat_load", int'(dut_o[1]), 2);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, 4'd0);
      chk($sformatf("sat_step%0d_o", i), int'(dut_o[1]), exp_sat[i]);
      chk($sformatf("sat_step%0d_tc", i), int'(dut_tc[1]), exp_satc[i]);
    end
    cycle(0, 0, 0, 0, 4'd0);
    chk("sat_idle_tc", int'(dut_tc[1]), 0);

    // Div=3: four enabled, four frozen, two enabled cycles.
    exp_pre = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
    cycle(1, 0, 0, 1, 4'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, (i < 4 || i >= 8), 1, 4'd0);
      chk($sformatf("pre%0d_o", i), int'(dut_o[2]), exp_pre[i]);
    end

    // Asynchronous reset mid-cycle while the count sits at 7.
    cycle(0, 1, 0, 1, 4'd7);
    chk("arst_pre_o", int'(dut_o[0]), 7);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("arst_o[%0d]", k), int'(dut_o[k]), 0);
      chk($sformatf("arst_tc[%0d]", k), int'(dut_tc[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 1, 1, 4'd0);
      chk($sformatf("arst_restart%0d", i), int'(dut_o[0]), i);
      chk($sformatf("arst_presc%0d", i), int'(dut_o[2]), (i == 3) ? 1 : 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(15) == 0), ($urandom_range(9) == 0),
            ($urandom_range(3) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updn_ctr.md
UPDN_CTR -- requirements
Module: updn_ctr

Interface
REQ-001 Parameter Width, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter MaxVal, default 2**Width-1: upper count bound, legal range 1..2**Width-1.
REQ-003 Parameter Mode, default CTR_MODE_WRAP: boundary behaviour, either CTR_MODE_WRAP or CTR_MODE_SAT.
REQ-004 Parameter PrescaleDiv, default 1: number of enabled cycles per count step, legal range 1..256.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 en_i  input  1  count enable; the prescaler advances only while it is high.
REQ-008 up_i  input  1  direction: 1 counts up, 0 counts down; sampled on every step.
REQ-009 clr_i  input  1  synchronous clear of the count and the prescaler.
REQ-010 load_i  input  1  synchronous load of load_val_i.
REQ-011 load_val_i  input  Width  load value.
REQ-012 o  output  Width  current count, registered.
REQ-013 tc_o  output  1  terminal-count pulse, registered.

Function
REQ-014 A step occurs in a cycle where en_i=1 and the prescaler tick is high.
- Prescaler counts enabled cycles 0..PrescaleDiv-1.
- Tick is high on the enabled cycle in which the prescaler holds PrescaleDiv-1.
- Prescaler then returns to 0.
- PrescaleDiv=1 gives a tick on every enabled cycle.
REQ-015 Per-cycle priority: clr_i > load_i > step > hold.
REQ-016 clr_i=1: next o=0; prescaler returns to 0; tc_o=0 next cycle.
REQ-017 load_i=1 (clr_i=0):
- next o=load_val_i when load_val_i<=MaxVal, otherwise next o=MaxVal (clamp).
- Prescaler returns to 0; tc_o=0 next cycle.
REQ-018 Step up with o<MaxVal: o+1. Step down with o>0: o-1.
REQ-019 Step up at o=MaxVal: next o=0 in WRAP mode; o holds at MaxVal in SAT mode.
REQ-020 Step down at o=0: next o=MaxVal in WRAP mode; o holds at 0 in SAT mode.
REQ-021 tc_o=1 for exactly the cycle after a step taken at a boundary (REQ-019/020), in both modes.
- tc_o=0 in every other cycle.
- Repeated saturating steps give repeated pulses.
REQ-022 en_i=0 freezes both o and the prescaler; clr_i and load_i still act.
REQ-023 All next-count arithmetic is Width bits with no carry-out port.
- MaxVal < 2**Width-1 still wraps at MaxVal, not at 2**Width-1.
REQ-024 A direction change mid-count takes effect on the next step, with no extra latency and no prescaler reset.
REQ-025 Latency: o and tc_o update one clock after the qualifying input cycle; there are no combinational input-to-output paths.

Reset
REQ-026 rst_ni=0 asynchronously forces o=0, tc_o=0 and prescaler=0, regardless of clk_i.
REQ-027 Reset asserted mid-count discards any pending step.
- After deassertion, the first tick needs a full PrescaleDiv enabled cycles.
REQ-028 Reset deassertion is treated as synchronous to clk_i by the integrator; the block contains no synchroniser.

Structure
REQ-029 Shared package ctr_pkg holds:
- the CTR_MODE_WRAP and CTR_MODE_SAT constants and their mode typedef;
- the PrescaleDiv upper limit.
REQ-030 One sub-module, ctr_prescaler, contains:
- parameter Div;
- ports clk_i, rst_ni, en_i, clr_i and tick_o;
- a counter width of clog2(Div), minimum 1.
- clr_i is driven by the parent's clr_i OR load_i.
REQ-031 Illegal parameter combinations halt elaboration with an error, not with silent truncation.

Verification
REQ-032 Wrap up (Width=4, MaxVal=9, WRAP, Div=1): en_i=1, up_i=1 for 12 cycles from reset.
- o runs 0..9, 0, 1.
- tc_o is high only in the cycle where o=0 after 9.
REQ-033 Saturate down (SAT, MaxVal=9): load 2, then up_i=0 for 5 steps.
- o goes 2, 1, 0, 0, 0, 0.
- tc_o is high in the 3 cycles following each step taken at o=0.
REQ-034 Prescale (Div=3, WRAP): en_i=1 continuously.
- o increments every 3rd cycle.
- Drop en_i for 4 cycles mid-period: o and phase freeze, and the step resumes at the remaining count.
REQ-035 Priority and clamp (MaxVal=9):
- clr_i=1, load_i=1, load_val_i=5 in the same cycle -> o=0.
- load_val_i=14 with load_i alone -> o=9.
REQ-036 Async reset: assert rst_ni between clock edges while o=7.
- o=0 and tc_o=0 before the next rising edge.
- Counting restarts from 0 after deassertion.
REQ-037 Direction flip at a boundary (WRAP, MaxVal=9): at o=9, set up_i=0 and step -> o=8 with tc_o=0.
